// File: rtl/count_history_display.sv
// -----------------------------------------------------------------------------
// count_history_display
//
// Display stage that sits downstream of the up/down counter.
//   - Samples Count on every clock edge and detects when its value changes.
//   - Pushes each new value into a 4-entry history. hist[0] is the newest
//     entry, and the oldest entry is dropped.
//   - Time-multiplexes the history onto a 4-digit active-low seven-segment
//     display. The newest value is shown on the rightmost digit (An[0]).
//   - All outputs are registered.
//
// Parameters
//   SCAN_DIV      Clk_Out cycles each digit is held before the scan moves on
//                 (1..255).
//
// Ports
//   Clk_Out       clock, shared with the counter
//   Rst           synchronous, active-high reset
//   Count[3:0]    counter value, synchronous to Clk_Out
//   Hold          freezes the history; the scan keeps running
//   An[3:0]       digit anodes, active-low, one-hot; An[0] is the newest digit
//   Seg[6:0]      segments, active-low, ordered {g,f,e,d,c,b,a}
//   Dp            decimal point, active-low; lit on digit 0 while Hold is high
//
// Build option
//   HIST_BLANK_EN When defined, a per-digit valid flag is kept, and digits
//                 that have never been filled are blanked. The anode still
//                 scans. When undefined, unfilled digits show "0".
// -----------------------------------------------------------------------------
module count_history_display #(
  parameter int SCAN_DIV = 4
) (
  input  logic       Clk_Out,
  input  logic       Rst,
  input  logic [3:0] Count,
  input  logic       Hold,
  output logic [3:0] An,
  output logic [6:0] Seg,
  output logic       Dp
);

  // The scan divider needs at least one bit, even when SCAN_DIV is 1.
  localparam int DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);

  localparam logic [6:0] SEG_OFF = 7'b1111111;
  localparam logic [3:0] AN_OFF  = 4'b1111;

  // Active-low hex glyphs, ordered {g,f,e,d,c,b,a}. 'b' and 'd' are lowercase.
  function automatic logic [6:0] hex7(input logic [3:0] v);
    logic [6:0] s;
    case (v)
      4'h0: s = 7'b1000000;
      4'h1: s = 7'b1111001;
      4'h2: s = 7'b0100100;
      4'h3: s = 7'b0110000;
      4'h4: s = 7'b0011001;
      4'h5: s = 7'b0010010;
      4'h6: s = 7'b0000010;
      4'h7: s = 7'b1111000;
      4'h8: s = 7'b0000000;
      4'h9: s = 7'b0010000;
      4'hA: s = 7'b0001000;
      4'hB: s = 7'b0000011;
      4'hC: s = 7'b1000110;
      4'hD: s = 7'b0100001;
      4'hE: s = 7'b0000110;
      default: s = 7'b0001110;  // 4'hF
    endcase
    return s;
  endfunction

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [3:0]       prev;
  logic [3:0]       hist [4];
  logic [DIV_W-1:0] div;
  logic [1:0]       idx;

  logic             chg;
  logic             push;
  logic             scan_step;
  logic [6:0]       seg_next;

  // Compare against the value seen on the previous edge. Because prev is
  // updated even while Hold is high, a value that was swallowed during Hold
  // does not turn into a late push when Hold is released.
  assign chg       = (Count != prev);
  assign push      = chg && !Hold;
  assign scan_step = (div == DIV_LAST);

  // ---------------------------------------------------------------------------
  // Change detect and history shift register
  // ---------------------------------------------------------------------------
  // NOTE: every register in this file is written with <= so that the whole
  // shift (hist[3] <= hist[2] ... hist[0] <= Count) uses the pre-edge values.
  // Using blocking '=' here would collapse the shift chain.
  always_ff @(posedge Clk_Out) begin
    if (Rst) begin
      prev <= 4'h0;
      // NOTE: the history is a small register file, not a RAM. It is cleared
      // explicitly because a reset must empty the display. Do not move it into
      // a block RAM, which cannot be reset like this.
      for (int i = 0; i < 4; i++) begin
        hist[i] <= 4'h0;
      end
    end else begin
      prev <= Count;
      if (push) begin
        hist[3] <= hist[2];
        hist[2] <= hist[1];
        hist[1] <= hist[0];
        hist[0] <= Count;
      end
    end
  end

`ifdef HIST_BLANK_EN
  // One fill flag per digit. The flags shift in lockstep with the history.
  logic [3:0] vld;

  always_ff @(posedge Clk_Out) begin
    if (Rst) begin
      vld <= 4'b0000;
    end else if (push) begin
      vld <= {vld[2:0], 1'b1};
    end
  end
`endif

  // ---------------------------------------------------------------------------
  // Scan counter: each digit stays active for SCAN_DIV cycles, then idx moves
  // on. idx is 2 bits wide, so it wraps from 3 back to 0 on its own.
  // ---------------------------------------------------------------------------
  always_ff @(posedge Clk_Out) begin
    if (Rst) begin
      div <= '0;
      idx <= 2'd0;
    end else if (scan_step) begin
      div <= '0;
      idx <= idx + 2'd1;
    end else begin
      div <= div + DIV_W'(1);
    end
  end

  // ---------------------------------------------------------------------------
  // Segment select for the digit currently being scanned
  // ---------------------------------------------------------------------------
  // NOTE: seg_next gets its full value first, before any conditional override.
  // That way no path through this always_comb leaves it unassigned, so no
  // latch is inferred.
  always_comb begin
    seg_next = hex7(hist[idx]);
`ifdef HIST_BLANK_EN
    if (!vld[idx]) begin
      seg_next = SEG_OFF;
    end
`endif
  end

  // ---------------------------------------------------------------------------
  // Output registers. An, Seg and Dp all load from the same idx, so the anode
  // and its segments always change on the same edge. They lag idx and hist
  // by one cycle.
  // ---------------------------------------------------------------------------
  always_ff @(posedge Clk_Out) begin
    if (Rst) begin
      An  <= AN_OFF;
      Seg <= SEG_OFF;
      Dp  <= 1'b1;
    end else begin
      An  <= ~(4'b0001 << idx);
      Seg <= seg_next;
      Dp  <= ~(Hold && (idx == 2'd0));
    end
  end

endmodule

// File: tb/tb_count_history_display.sv
// -----------------------------------------------------------------------------
// tb_count_history_display
//
// Self-checking bench for count_history_display, run with SCAN_DIV = 2.
//   - A table of per-cycle vectors covers reset release, the scan order and
//     the first pushes.
//   - Hand-written sequences cover wrap-around, idle, Hold, Hold on the same
//     cycle as a change, and a reset in the middle of operation.
// Inputs are driven on the falling edge; outputs are sampled on the falling
// edge.
// -----------------------------------------------------------------------------
module tb_count_history_display;

  localparam int SCAN_DIV = 2;

  // Active-low glyphs {g,f,e,d,c,b,a}, written out by hand.
  localparam logic [6:0] G_0 = 7'b1000000;
  localparam logic [6:0] G_1 = 7'b1111001;
  localparam logic [6:0] G_2 = 7'b0100100;
  localparam logic [6:0] G_3 = 7'b0110000;
  localparam logic [6:0] G_4 = 7'b0011001;
  localparam logic [6:0] G_8 = 7'b0000000;
  localparam logic [6:0] G_E = 7'b0000110;
  localparam logic [6:0] G_F = 7'b0001110;
  localparam logic [6:0] G_OFF = 7'b1111111;
`ifdef HIST_BLANK_EN
  localparam logic [6:0] SE = G_OFF;  // unfilled digit is blanked
`else
  localparam logic [6:0] SE = G_0;    // unfilled digit shows zero
`endif

  logic       Clk_Out;
  logic       Rst;
  logic [3:0] Count;
  logic       Hold;
  logic [3:0] An;
  logic [6:0] Seg;
  logic       Dp;

  int n_tests = 0;
  int n_fail  = 0;

  count_history_display #(.SCAN_DIV(SCAN_DIV)) dut (
    .Clk_Out (Clk_Out),
    .Rst     (Rst),
    .Count   (Count),
    .Hold    (Hold),
    .An      (An),
    .Seg     (Seg),
    .Dp      (Dp)
  );

  initial Clk_Out = 1'b0;
  always #5 Clk_Out = ~Clk_Out;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [3:0] count;
    logic       hold;
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;
  } vec_t;

  vec_t vecs [20];

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Wait, for a bounded number of cycles, until digit d is the active anode.
  task automatic wait_digit(input int d, output logic ok);
    logic [3:0] tgt;
    tgt = 4'b0001 << d;
    tgt = ~tgt;
    ok  = 1'b0;
    for (int n = 0; n < 12 && !ok; n++) begin
      @(negedge Clk_Out);
      if (An == tgt) ok = 1'b1;
    end
    if (!ok) check($sformatf("scan reach digit %0d", d), {4'h0, An}, {4'h0, tgt});
  endtask

  task automatic check_digits(input string tag, input logic [6:0] e0, input logic [6:0] e1,
                              input logic [6:0] e2, input logic [6:0] e3);
    logic ok;
    logic [6:0] e [4];
    e[0] = e0; e[1] = e1; e[2] = e2; e[3] = e3;
    for (int d = 0; d < 4; d++) begin
      wait_digit(d, ok);
      if (ok) check($sformatf("%s seg digit %0d", tag, d), {1'b0, Seg}, {1'b0, e[d]});
    end
  endtask

  initial begin
    logic ok;
    logic [3:0] prev_an;

    // ---------------- per-cycle vectors after reset release ----------------
    // Each vector's inputs are driven before edge k; the expected outputs are
    // the ones seen after edge k.
    vecs[0]  = '{4'h0, 1'b0, 4'b1110, SE,  1'b1};
    vecs[1]  = '{4'h0, 1'b0, 4'b1110, SE,  1'b1};
    vecs[2]  = '{4'h0, 1'b0, 4'b1101, SE,  1'b1};
    vecs[3]  = '{4'h0, 1'b0, 4'b1101, SE,  1'b1};
    vecs[4]  = '{4'h0, 1'b0, 4'b1011, SE,  1'b1};
    vecs[5]  = '{4'h0, 1'b0, 4'b1011, SE,  1'b1};
    vecs[6]  = '{4'h0, 1'b0, 4'b0111, SE,  1'b1};
    vecs[7]  = '{4'h0, 1'b0, 4'b0111, SE,  1'b1};
    vecs[8]  = '{4'h1, 1'b0, 4'b1110, SE,  1'b1};
    vecs[9]  = '{4'h2, 1'b0, 4'b1110, G_1, 1'b1};
    vecs[10] = '{4'h3, 1'b0, 4'b1101, G_1, 1'b1};
    vecs[11] = '{4'h4, 1'b0, 4'b1101, G_2, 1'b1};
    vecs[12] = '{4'h4, 1'b0, 4'b1011, G_2, 1'b1};
    vecs[13] = '{4'h4, 1'b0, 4'b1011, G_2, 1'b1};
    vecs[14] = '{4'h4, 1'b0, 4'b0111, G_1, 1'b1};
    vecs[15] = '{4'h4, 1'b0, 4'b0111, G_1, 1'b1};
    vecs[16] = '{4'h4, 1'b0, 4'b1110, G_4, 1'b1};
    vecs[17] = '{4'h4, 1'b0, 4'b1110, G_4, 1'b1};
    vecs[18] = '{4'h4, 1'b0, 4'b1101, G_3, 1'b1};
    vecs[19] = '{4'h4, 1'b0, 4'b1101, G_3, 1'b1};

    // ---------------- reset ----------------
    Rst = 1'b1; Count = 4'h0; Hold = 1'b0;
    repeat (2) @(negedge Clk_Out);
    check("reset An",  {4'h0, An},  8'h0F);
    check("reset Seg", {1'b0, Seg}, {1'b0, G_OFF});
    check("reset Dp",  {7'h0, Dp},  8'h01);
    Rst = 1'b0;

    // ---------------- scan and push table ----------------
    for (int i = 0; i < 20; i++) begin
      Count = vecs[i].count;
      Hold  = vecs[i].hold;
      @(negedge Clk_Out);
      check($sformatf("vec%0d An", i),  {4'h0, An},  {4'h0, vecs[i].an});
      check($sformatf("vec%0d Seg", i), {1'b0, Seg}, {1'b0, vecs[i].seg});
      check($sformatf("vec%0d Dp", i),  {7'h0, Dp},  {7'h0, vecs[i].dp});
    end

    // ---------------- wrap E -> F -> 0, then idle ----------------
    Count = 4'hE; @(negedge Clk_Out);
    Count = 4'hF; @(negedge Clk_Out);
    Count = 4'h0; repeat (3) @(negedge Clk_Out);
    check_digits("wrap", G_0, G_F, G_E, G_4);
    repeat (20) @(negedge Clk_Out);
    check_digits("idle", G_0, G_F, G_E, G_4);

    // ---------------- Hold: changes are lost ----------------
    Hold = 1'b1;
    Count = 4'h5; @(negedge Clk_Out);
    Count = 4'h6; @(negedge Clk_Out);
    Count = 4'h7; repeat (2) @(negedge Clk_Out);
    wait_digit(0, ok);
    if (ok) begin
      check("hold Dp digit0", {7'h0, Dp}, 8'h00);
      check("hold Seg digit0", {1'b0, Seg}, {1'b0, G_0});
    end
    wait_digit(1, ok);
    if (ok) check("hold Dp digit1", {7'h0, Dp}, 8'h01);
    wait_digit(3, ok);
    if (ok) check("hold Dp digit3", {7'h0, Dp}, 8'h01);
    Hold = 1'b0;  // Count stays at 7, which equals prev, so nothing is pushed
    repeat (2) @(negedge Clk_Out);
    check_digits("release", G_0, G_F, G_E, G_4);
    wait_digit(0, ok);
    if (ok) check("release Dp digit0", {7'h0, Dp}, 8'h01);
    Count = 4'h8; repeat (3) @(negedge Clk_Out);
    check_digits("push8", G_8, G_0, G_F, G_E);

    // ---------------- Hold on the same cycle as a change ----------------
    Count = 4'h2; @(negedge Clk_Out);
    Hold = 1'b1; Count = 4'h3; @(negedge Clk_Out);
    Hold = 1'b0; repeat (4) @(negedge Clk_Out);
    check_digits("simul", G_2, G_8, G_0, G_F);

    // ---------------- reset mid-operation while idx == 2 ----------------
    Count = 4'h4; @(negedge Clk_Out);
    Count = 4'h5; @(negedge Clk_Out);
    Count = 4'h6; @(negedge Clk_Out);
    ok = 1'b0;
    for (int n = 0; n < 20 && !ok; n++) begin
      prev_an = An;
      @(negedge Clk_Out);
      // Digit 2 has just become active, so idx is still 2 at the next edge.
      if (An == 4'b1011 && prev_an == 4'b1101) ok = 1'b1;
    end
    check("find idx2 window", {7'h0, ok}, 8'h01);
    Rst = 1'b1; Count = 4'h0;
    @(negedge Clk_Out);
    check("midrst An",  {4'h0, An},  8'h0F);
    check("midrst Seg", {1'b0, Seg}, {1'b0, G_OFF});
    check("midrst Dp",  {7'h0, Dp},  8'h01);
    Rst = 1'b0;
    @(negedge Clk_Out);
    check("restart An e1", {4'h0, An}, 8'h0E);
    @(negedge Clk_Out);
    check("restart An e2", {4'h0, An}, 8'h0E);
    @(negedge Clk_Out);
    check("restart An e3", {4'h0, An}, 8'h0D);
    check_digits("cleared", SE, SE, SE, SE);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
